color_sequencer: RTL

Parametrised successor to the fixed four-colour counter: steps a colour code through an inclusive range [FIRST..LAST], up or down, with wrap-around. Two step sources: free-running mode with a prescaler, or single-step mode on rising edges of a continue button. Adds hold, synchronous load, and step/wrap strobes for the display and game-control logic downstream.

---
 rtl/color_sequencer.sv | 62 ++++++
 1 files changed

// File: rtl/color_sequencer.sv
// color_sequencer: steps a colour code through [FIRST..LAST] up or down with wrap,
// driven by a prescaler (auto) or continue_btn rising edges, with hold and load.
module color_sequencer #(
    parameter int WIDTH    = 4,
    parameter int FIRST    = 2,
    parameter int LAST     = 5,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             dir,
    input  logic             continue_btn,
    input  logic             hold,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] color,
    output logic             step,
    output logic             wrap
);
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] F = WIDTH'(FIRST);
    localparam logic [WIDTH-1:0] L = WIDTH'(LAST);
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
    logic [PW-1:0] pre;
    logic btn_q, step_req, in_range, load_ok, nwrap;
    logic [WIDTH-1:0] nxt;
    always_comb begin
        step_req = mode ? (continue_btn & ~btn_q) : (pre == PMAX);
        in_range = color >= F && color <= L;
        load_ok  = load_val >= F && load_val <= L;
        nwrap    = in_range && (dir ? color == F : color == L);
        // range checks precede +/-1, so the arithmetic never overflows
        nxt      = !in_range ? F : nwrap ? (dir ? L : F) : dir ? color - 1'b1 : color + 1'b1;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            color <= F;
            step  <= 1'b0;
            wrap  <= 1'b0;
            pre   <= '0;
            btn_q <= 1'b0;
        end else begin
            btn_q <= continue_btn;
            step  <= 1'b0;
            wrap  <= 1'b0;
            if (load) begin
                color <= load_ok ? load_val : F;
                pre   <= '0;
            end else if (hold) begin
                pre <= mode ? '0 : pre;
            end else begin
                pre <= (mode || pre == PMAX) ? '0 : pre + 1'b1;
                if (step_req) begin
                    color <= nxt;
                    step  <= 1'b1;
                    wrap  <= nwrap;
                end
            end
        end
    end
endmodule
